// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin memory arbiter and its picker.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  // Wide enough for any supported DATA_W; users slice off the low DATA_W/8 bits.
  localparam logic [63:0] BE_ALL = '1;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_mem_arbiter_if.sv
// Core-side and memory-side signal bundle of the arbiter.
interface rr_mem_arbiter_if #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES*ADDR_W-1:0] core_adr;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*BE_W-1:0]   core_be;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_gnt;
  logic [NUM_CORES-1:0]        core_r_valid;
  logic [NUM_CORES-1:0]        core_err;
  logic [DATA_W-1:0]           core_rdata;

  logic                        mem_req;
  logic [ADDR_W-1:0]           mem_adr;
  logic                        mem_we;
  logic [BE_W-1:0]             mem_be;
  logic [DATA_W-1:0]           mem_wdata;
  logic                        mem_gnt;
  logic                        mem_r_valid;
  logic [DATA_W-1:0]           mem_rdata;

  modport master (
    input  core_req, core_adr, core_we, core_be, core_wdata,
    input  mem_gnt, mem_r_valid, mem_rdata,
    output core_gnt, core_r_valid, core_err, core_rdata,
    output mem_req, mem_adr, mem_we, mem_be, mem_wdata
  );

  modport slave (
    output core_req, core_adr, core_we, core_be, core_wdata,
    output mem_gnt, mem_r_valid, mem_rdata,
    input  core_gnt, core_r_valid, core_err, core_rdata,
    input  mem_req, mem_adr, mem_we, mem_be, mem_wdata
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational winner selection: search the request vector starting at ptr_i,
// return the first set bit as one-hot and as an index.
module rr_picker import arb_pkg::*; #(
  parameter int NUM_CORES = 2,
  parameter bit RR_MODE   = 1'b1,
  localparam int IW       = idx_w(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [IW-1:0]        ptr_i,
  output logic [NUM_CORES-1:0] gnt_o,
  output logic [IW-1:0]        idx_o,
  output logic                 valid_o
);

  logic [IW-1:0] start;
  assign start = RR_MODE ? ptr_i : '0;

  always_comb begin
    logic       found;
    logic [IW:0] j;
    found   = 1'b0;
    j       = '0;
    gnt_o   = '0;
    idx_o   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      j = {1'b0, start} + (IW+1)'(i);
      if (j >= (IW+1)'(NUM_CORES)) j = j - (IW+1)'(NUM_CORES);
      if (!found && req_i[j[IW-1:0]]) begin
        found              = 1'b1;
        gnt_o[j[IW-1:0]]   = 1'b1;
        idx_o              = j[IW-1:0];
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/rr_mem_arbiter.sv
// N-core arbiter for one shared memory port: one outstanding transaction,
// response routed to the owner, timeout turns a lost response into an error.
//   state    | meaning
//   IDLE     | no transaction; pick a winner when any core requests
//   REQ      | mem_req held with latched fields until mem_gnt
//   WAIT_RSP | granted; waiting for mem_r_valid or timeout
module rr_mem_arbiter import arb_pkg::*; #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_MODE   = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              res,
  rr_mem_arbiter_if.master  bus,
  output logic              late_rsp
);

  localparam int IW    = idx_w(NUM_CORES);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e        state_q;
  logic [IW-1:0]     owner_q, rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_req_q, mem_we_q, late_q, to_q;
  logic [ADDR_W-1:0] mem_adr_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [NUM_CORES-1:0] pick_gnt, own_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid, rsp_now;
  logic [ADDR_W-1:0]    sel_adr_d;
  logic                 sel_we_d;
  logic [BE_W-1:0]      sel_be_d;
  logic [DATA_W-1:0]    sel_wdata_d;
  logic [IW:0]          ptr_inc;

  rr_picker #(.NUM_CORES(NUM_CORES), .RR_MODE(RR_MODE != 0)) u_picker (
    .req_i   (bus.core_req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    sel_adr_d   = '0;
    sel_we_d    = 1'b0;
    sel_be_d    = '0;
    sel_wdata_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pick_gnt[i]) begin
        sel_adr_d   = bus.core_adr[i*ADDR_W +: ADDR_W];
        sel_we_d    = bus.core_we[i];
        sel_be_d    = bus.core_be[i*BE_W +: BE_W];
        sel_wdata_d = bus.core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    own_oh          = '0;
    own_oh[owner_q] = 1'b1;
  end

  assign ptr_inc  = {1'b0, owner_q} + 1'b1;
  assign rr_ptr_d = (ptr_inc == (IW+1)'(NUM_CORES)) ? '0 : ptr_inc[IW-1:0];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_adr_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= BE_ALL[BE_W-1:0];
      mem_wdata_q <= '0;
      late_q      <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      to_q <= 1'b0;
      // Any response outside WAIT_RSP has no owner and is discarded.
      if (bus.mem_r_valid && state_q != WAIT_RSP) late_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q     <= pick_idx;
            mem_req_q   <= 1'b1;
            mem_adr_q   <= sel_adr_d;
            mem_we_q    <= sel_we_d;
            mem_be_q    <= sel_be_d;
            mem_wdata_q <= sel_wdata_d;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= '0;
            state_q   <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus.mem_r_valid) begin
            state_q <= IDLE;
          end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
            to_q    <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_now = (state_q == WAIT_RSP) && bus.mem_r_valid;

  assign bus.core_gnt     = (state_q == REQ && bus.mem_gnt) ? own_oh : '0;
  assign bus.core_r_valid = (rsp_now || to_q) ? own_oh : '0;
  assign bus.core_err     = to_q ? own_oh : '0;
  assign bus.core_rdata   = rsp_now ? bus.mem_rdata : '0;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign late_rsp      = late_q;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter see identical stimulus;
// expected grants/responses are queued per instance and popped by a negedge monitor.
module tb_rr_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0] req = '0;
  logic [NC-1:0] we  = '0;
  logic [AW-1:0] adr   [NC];
  logic [BW-1:0] be    [NC];
  logic [DW-1:0] wdata [NC];
  logic          mem_gnt     = 1'b0;
  logic          mem_r_valid = 1'b0;
  logic [DW-1:0] mem_rdata   = '0;
  logic          late_a, late_b;

  rr_mem_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) ifa ();
  rr_mem_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) ifb ();

  for (genvar g = 0; g < NC; g++) begin : g_pack
    assign ifa.core_adr[g*AW +: AW]   = adr[g];
    assign ifb.core_adr[g*AW +: AW]   = adr[g];
    assign ifa.core_be[g*BW +: BW]    = be[g];
    assign ifb.core_be[g*BW +: BW]    = be[g];
    assign ifa.core_wdata[g*DW +: DW] = wdata[g];
    assign ifb.core_wdata[g*DW +: DW] = wdata[g];
  end
  assign ifa.core_req = req;          assign ifb.core_req = req;
  assign ifa.core_we = we;            assign ifb.core_we = we;
  assign ifa.mem_gnt = mem_gnt;       assign ifb.mem_gnt = mem_gnt;
  assign ifa.mem_r_valid = mem_r_valid; assign ifb.mem_r_valid = mem_r_valid;
  assign ifa.mem_rdata = mem_rdata;   assign ifb.mem_rdata = mem_rdata;

  rr_mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TO))
    dut_a (.clk(clk), .res(res), .bus(ifa.master), .late_rsp(late_a));
  rr_mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(TO))
    dut_b (.clk(clk), .res(res), .bus(ifb.master), .late_rsp(late_b));

  typedef struct {
    logic [NC-1:0] who;
    logic [AW-1:0] adr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } gnt_t;

  typedef struct {
    logic [NC-1:0] who;
    logic [NC-1:0] err;
    logic [DW-1:0] rdata;
  } rsp_t;

  gnt_t gq_a[$], gq_b[$];
  rsp_t rq_a[$], rq_b[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic gnt_t mk_gnt(input int c);
    gnt_t e;
    e.who   = NC'(1) << c;
    e.adr   = adr[c];
    e.we    = we[c];
    e.be    = be[c];
    e.wdata = wdata[c];
    return e;
  endfunction

  function automatic rsp_t mk_rsp(input int c, input bit err, input logic [DW-1:0] d);
    rsp_t e;
    e.who   = NC'(1) << c;
    e.err   = err ? (NC'(1) << c) : '0;
    e.rdata = d;
    return e;
  endfunction

  task automatic push_g(input int ca, input int cb);
    gq_a.push_back(mk_gnt(ca));
    gq_b.push_back(mk_gnt(cb));
  endtask

  task automatic push_r(input int ca, input int cb, input bit err, input logic [DW-1:0] d);
    rq_a.push_back(mk_rsp(ca, err, d));
    rq_b.push_back(mk_rsp(cb, err, d));
  endtask

  task automatic mon_gnt(input bit d, input logic [NC-1:0] g, input logic [AW-1:0] madr,
                         input logic mwe, input logic [BW-1:0] mbe, input logic [DW-1:0] mwd);
    gnt_t e;
    string t;
    t = d ? "b" : "a";
    if (g === '0) return;
    if ((d ? gq_b.size() : gq_a.size()) == 0) begin
      chk({"gnt_unexpected_", t}, 64'(g), 64'd0);
      return;
    end
    if (d) e = gq_b.pop_front(); else e = gq_a.pop_front();
    chk({"gnt_who_", t}, 64'(g), 64'(e.who));
    chk({"gnt_adr_", t}, 64'(madr), 64'(e.adr));
    chk({"gnt_we_", t}, 64'(mwe), 64'(e.we));
    chk({"gnt_be_", t}, 64'(mbe), 64'(e.be));
    chk({"gnt_wdata_", t}, 64'(mwd), 64'(e.wdata));
  endtask

  task automatic mon_rsp(input bit d, input logic [NC-1:0] rv, input logic [NC-1:0] er,
                         input logic [DW-1:0] rd);
    rsp_t e;
    string t;
    t = d ? "b" : "a";
    if (rv === '0 && er === '0) return;
    if ((d ? rq_b.size() : rq_a.size()) == 0) begin
      chk({"rsp_unexpected_", t}, 64'({rv, er}), 64'd0);
      return;
    end
    if (d) e = rq_b.pop_front(); else e = rq_a.pop_front();
    chk({"rsp_who_", t}, 64'(rv), 64'(e.who));
    chk({"rsp_err_", t}, 64'(er), 64'(e.err));
    chk({"rsp_rdata_", t}, 64'(rd), 64'(e.rdata));
  endtask

  always @(negedge clk) begin
    mon_gnt(1'b0, ifa.core_gnt, ifa.mem_adr, ifa.mem_we, ifa.mem_be, ifa.mem_wdata);
    mon_gnt(1'b1, ifb.core_gnt, ifb.mem_adr, ifb.mem_we, ifb.mem_be, ifb.mem_wdata);
    mon_rsp(1'b0, ifa.core_r_valid, ifa.core_err, ifa.core_rdata);
    mon_rsp(1'b1, ifb.core_r_valid, ifb.core_err, ifb.core_rdata);
  end

  // Plays the memory: waits for mem_req, grants after gd cycles, answers rd cycles later.
  task automatic mem_txn(input int gd, input int rd, input logic [DW-1:0] d,
                         input bit respond, output int waited);
    waited = 0;
    while (ifa.mem_req !== 1'b1 && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    if (ifa.mem_req !== 1'b1) chk("mem_req_wait", 64'(ifa.mem_req), 64'd1);
    repeat (gd) begin @(posedge clk); #1; end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    if (respond) begin
      repeat (rd) begin @(posedge clk); #1; end
      mem_r_valid = 1'b1;
      mem_rdata   = d;
      @(posedge clk); #1;
      mem_r_valid = 1'b0;
      mem_rdata   = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    res = 1'b0;
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string t, input logic mreq, input logic [AW-1:0] madr,
                           input logic mwe, input logic [BW-1:0] mbe, input logic [DW-1:0] mwd,
                           input logic [NC-1:0] g, input logic [NC-1:0] rv,
                           input logic [NC-1:0] er, input logic [DW-1:0] rd, input logic late);
    chk({"rst_mem_req_", t}, 64'(mreq), 64'd0);
    chk({"rst_mem_adr_", t}, 64'(madr), 64'd0);
    chk({"rst_mem_we_", t}, 64'(mwe), 64'd0);
    chk({"rst_mem_be_", t}, 64'(mbe), 64'hF);
    chk({"rst_mem_wdata_", t}, 64'(mwd), 64'd0);
    chk({"rst_core_gnt_", t}, 64'(g), 64'd0);
    chk({"rst_core_r_valid_", t}, 64'(rv), 64'd0);
    chk({"rst_core_err_", t}, 64'(er), 64'd0);
    chk({"rst_core_rdata_", t}, 64'(rd), 64'd0);
    chk({"rst_late_", t}, 64'(late), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int i = 0; i < NC; i++) begin
      adr[i] = '0; be[i] = '1; wdata[i] = '0;
    end

    // Reset held with random inputs.
    repeat (4) begin
      @(posedge clk); #1;
      req = NC'($urandom); we = NC'($urandom);
      for (int i = 0; i < NC; i++) begin
        adr[i] = $urandom; be[i] = BW'($urandom); wdata[i] = $urandom;
      end
      mem_gnt = 1'($urandom); mem_r_valid = 1'($urandom); mem_rdata = $urandom;
      @(negedge clk);
      chk_reset("a", ifa.mem_req, ifa.mem_adr, ifa.mem_we, ifa.mem_be, ifa.mem_wdata,
                ifa.core_gnt, ifa.core_r_valid, ifa.core_err, ifa.core_rdata, late_a);
      chk_reset("b", ifb.mem_req, ifb.mem_adr, ifb.mem_we, ifb.mem_be, ifb.mem_wdata,
                ifb.core_gnt, ifb.core_r_valid, ifb.core_err, ifb.core_rdata, late_b);
    end
    @(posedge clk); #1;
    req = '0; we = '0; mem_gnt = 1'b0; mem_r_valid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < NC; i++) begin
      adr[i] = '0; be[i] = '1; wdata[i] = '0;
    end
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;

    // Single read from core 1: mem_req at t+1, gnt at t+2, response at t+4.
    adr[1] = 32'h100;
    req    = 4'b0010;
    push_g(1, 1);
    push_r(1, 1, 1'b0, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("lat_mem_req_a", 64'(ifa.mem_req), 64'd1);
    chk("lat_mem_adr_a", 64'(ifa.mem_adr), 64'h100);
    chk("lat_mem_req_b", 64'(ifb.mem_req), 64'd1);
    mem_txn(1, 1, 32'hDEADBEEF, 1'b1, w);
    req = '0;

    // All four request continuously: RR grants 0,1,2,3,0; fixed grants 0 each time.
    do_reset();
    for (int i = 0; i < NC; i++) begin
      adr[i]   = 32'h200 + 32'(4 * i);
      we[i]    = i[0];
      be[i]    = BW'(1 << i);
      wdata[i] = 32'hA0 + 32'(i);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_g(k % NC, 0);
      push_r(k % NC, 0, 1'b0, 32'h1111_0000 + 32'(k));
      mem_txn(0, 0, 32'h1111_0000 + 32'(k), 1'b1, w);
      chk("b2b_spacing", 64'(w), 64'd1);
    end
    req = '0;

    // Cores 0 and 2: RR alternates starting from pointer 1, fixed always picks 0.
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      push_g((k % 2 == 0) ? 2 : 0, 0);
      push_r((k % 2 == 0) ? 2 : 0, 0, 1'b0, 32'h2222_0000 + 32'(k));
      mem_txn(1, 2, 32'h2222_0000 + 32'(k), 1'b1, w);
    end
    req = '0;

    // Timeout: no response, error pulse after 8 WAIT_RSP cycles, then a late response.
    adr[3] = 32'h300;
    req    = 4'b1000;
    push_g(3, 3);
    push_r(3, 3, 1'b1, 32'h0);
    mem_txn(0, 0, 32'h0, 1'b0, w);
    repeat (7) begin @(posedge clk); #1; end
    chk("to_early_a", 64'(ifa.core_r_valid), 64'd0);
    @(posedge clk); #1;
    chk("to_pulse_a", 64'(ifa.core_r_valid), 64'b1000);
    chk("to_err_b", 64'(ifb.core_err), 64'b1000);
    req = '0;
    @(posedge clk); #1;
    chk("to_single_a", 64'(ifa.core_r_valid), 64'd0);
    chk("late_before_a", 64'(late_a), 64'd0);
    mem_r_valid = 1'b1;
    mem_rdata   = 32'h55;
    @(negedge clk);
    chk("late_no_rv_a", 64'(ifa.core_r_valid), 64'd0);
    @(posedge clk); #1;
    mem_r_valid = 1'b0;
    mem_rdata   = '0;
    chk("late_set_a", 64'(late_a), 64'd1);
    chk("late_set_b", 64'(late_b), 64'd1);

    // Write from core 0, then reset during WAIT_RSP drops the transaction.
    do_reset();
    chk("late_clr_a", 64'(late_a), 64'd0);
    adr[0] = 32'h400; we[0] = 1'b1; be[0] = 4'b0011; wdata[0] = 32'h1234;
    req = 4'b0001;
    push_g(0, 0);
    mem_txn(0, 0, 32'h0, 1'b0, w);
    req = '0;
    #2 res = 1'b0;
    @(negedge clk);
    chk("midrst_mem_req_a", 64'(ifa.mem_req), 64'd0);
    chk("midrst_rv_a", 64'(ifa.core_r_valid), 64'd0);
    @(posedge clk); #1;
    res = 1'b1;
    mem_r_valid = 1'b1;
    mem_rdata   = 32'h77;
    @(negedge clk);
    chk("midrst_no_rv_a", 64'(ifa.core_r_valid), 64'd0);
    chk("midrst_no_rv_b", 64'(ifb.core_r_valid), 64'd0);
    @(posedge clk); #1;
    mem_r_valid = 1'b0;
    repeat (TO + 4) @(posedge clk);
    #1;

    chk("gq_a_left", 64'(gq_a.size()), 64'd0);
    chk("gq_b_left", 64'(gq_b.size()), 64'd0);
    chk("rq_a_left", 64'(rq_a.size()), 64'd0);
    chk("rq_b_left", 64'(rq_b.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_mem_arbiter.md
# rr_mem_arbiter

Parametrised N-core arbiter sharing one memory port (instruction or data bus) between `NUM_CORES` requesters, using the codebase's req/gnt/r_valid protocol. It supports round-robin or fixed priority and allows one outstanding transaction at a time. The response goes back only to the owning core, and a response timeout returns an error instead of hanging the system. Two instances sit between the cores and memory: one on the instruction bus with write-enable tied low, and one on the data bus.

## Interface
- `NUM_CORES`, default 2: number of requesters, 2..8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte enable width is `DATA_W/8`.
- `RR_MODE`, default 1: 1 = round-robin; 0 = fixed priority with core 0 highest.
- `TIMEOUT`, default 64: cycles to wait for `mem_r_valid` after `mem_gnt`; 0 disables the timeout.
- `clk` in, 1: clock; all state changes on the rising edge.
- `res` in, 1: asynchronous, active-low reset.
- `core_req` in, `NUM_CORES`: per-core request; held with its fields until `core_gnt`.
- `core_adr` in, `NUM_CORES*ADDR_W`: packed addresses; core i occupies slice i.
- `core_we` in, `NUM_CORES`: per-core write enable.
- `core_be` in, `NUM_CORES*DATA_W/8`: packed byte enables.
- `core_wdata` in, `NUM_CORES*DATA_W`: packed write data.
- `core_gnt` out, `NUM_CORES`: one-hot accept pulse.
- `core_r_valid` out, `NUM_CORES`: one-hot response pulse.
- `core_err` out, `NUM_CORES`: qualifies `core_r_valid`; 1 = timed out.
- `core_rdata` out, `DATA_W`: shared read data; valid only with `core_r_valid`.
- `mem_req`, `mem_adr`, `mem_we`, `mem_be`, `mem_wdata` out: request to memory, all registered.
- `mem_gnt`, `mem_r_valid` in, 1; `mem_rdata` in, `DATA_W`: memory handshake inputs.
- `late_rsp` out, 1: sticky flag; set when `mem_r_valid` is dropped; cleared only by reset.

## Operation
- States: IDLE, REQ, WAIT_RSP.
- IDLE: if any `core_req` bit is set, the picker selects the winner. Its index goes to `owner`; its adr/we/be/wdata are latched into the `mem_*` registers; `mem_req` is set to 1; next state REQ.
  - Round-robin search starts at `rr_ptr`.
  - Fixed priority picks the lowest set index.
- REQ: `mem_req` and the `mem_*` fields are held stable.
  - When `mem_gnt`=1: `core_gnt[owner]`=1 combinationally in the same cycle; `mem_req` clears; `rr_ptr` becomes (owner+1) mod `NUM_CORES`; timeout counter clears; next state WAIT_RSP.
- WAIT_RSP, normal response: when `mem_r_valid`=1, `core_r_valid[owner]`=1 and `core_rdata`=`mem_rdata`, both combinational; next state IDLE.
- WAIT_RSP, timeout: if the counter reaches `TIMEOUT-1` with no `mem_r_valid`, the arbiter registers a one-cycle `core_r_valid[owner]`=1 with `core_err[owner]`=1 and `core_rdata`=0; next state IDLE.
- `mem_r_valid` in IDLE or REQ is dropped and sets `late_rsp`.
- A core dropping `core_req` while in REQ does not abort the transaction; the latched request completes.
- Requests arriving while not in IDLE wait. No core waits more than `NUM_CORES` transactions in RR mode.
- Simultaneous `mem_gnt` and `mem_r_valid` in REQ: the grant is taken and the response is dropped as late.

## Timing
- Reset values: state IDLE; `owner` 0; `rr_ptr` 0; counter 0; `mem_req` 0; `mem_adr` 0; `mem_we` 0; `mem_be` all ones; `mem_wdata` 0; `late_rsp` 0.
- All `core_*` outputs are 0 while `res` is low.
- Reset mid-transaction abandons it; nothing is delivered to the core.
- Request latency: `core_req` in cycle t gives `mem_req` at t+1.
- `core_gnt` appears in the same cycle as `mem_gnt`.
- Response: zero added latency, except a timeout error, which is registered (one cycle).
- Minimum back-to-back spacing: IDLE→REQ→WAIT_RSP→IDLE, i.e. 3 cycles per transaction with a 0-wait memory.
- `core_gnt`, `core_r_valid` and `core_err` are single-cycle pulses and one-hot or zero.

## Structure
- Package `arb_pkg`: state enum (IDLE=2'd0, REQ=2'd1, WAIT_RSP=2'd2), `BE_ALL` constant, and the `idx_w(NUM_CORES)` helper function.
- Sub-module `rr_picker`: combinational request vector + start pointer → one-hot grant and index. `RR_MODE`=0 drives the start pointer with 0. Reusable by the future cache arbiter.
- Top level: FSM, field registers, timeout counter, response routing.

## Test plan
- 1 — Reset: `res` low, random inputs → all outputs at their reset values; `mem_be`=4'hF.
- 2 — Single read: NUM_CORES=2, core 1 requests adr 0x100 → `mem_req` at t+1 with `mem_adr`=0x100. With `mem_gnt` at t+2: `core_gnt`=2'b10 at t+2. With `mem_r_valid` at t+4 and `mem_rdata`=0xDEADBEEF: `core_r_valid`=2'b10 and `core_rdata`=0xDEADBEEF at t+4.
- 3 — Round-robin fairness: 4 cores, all requesting continuously, 0-wait memory → grant order 0,1,2,3,0.
- 4 — Fixed priority (`RR_MODE`=0): cores 0 and 2 requesting continuously → core 0 wins every time; core 2 is never granted.
- 5 — Timeout: `TIMEOUT`=8, no `mem_r_valid` → exactly one `core_r_valid`+`core_err` pulse to the owner with `core_rdata`=0 after 8 WAIT_RSP cycles. A later `mem_r_valid` then sets `late_rsp` and produces no `core_r_valid`.
- 6 — Write with reset mid-flight: core 0 writes `we`=1, `be`=4'b0011, data 0x1234 → the `mem_*` fields match. Asserting `res` low during WAIT_RSP → IDLE, and no response is delivered.
